// File: rtl/pulse_monitor_pkg.sv
// Shared types and helpers for the pulse_monitor block.
package pulse_monitor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE,
        MON_SEARCH,
        MON_LOCKED,
        MON_LOST
    } mon_state_e;

    // Increment that sticks at maxv; callers cast to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge event detector for pulse_in.
// Define PULSE_MONITOR_SYNC_EN to add a 2-flop synchronizer ahead of the edge detect.
module pulse_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic pulse_in,
    output logic pulse_ev
);

    logic pulse_s;
    logic pulse_q;

`ifdef PULSE_MONITOR_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= {sync_q[0], pulse_in};
    end

    assign pulse_s = sync_q[1];
`else
    assign pulse_s = pulse_in;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pulse_q <= 1'b0;
        else         pulse_q <= pulse_s;
    end

    assign pulse_ev = pulse_s & ~pulse_q;

endmodule

// File: rtl/pulse_monitor.sv
// Periodic pulse monitor: measures the inter-pulse period, tracks lock and flags early/missing pulses.
// Optional input synchronizer via PULSE_MONITOR_SYNC_EN (see pulse_edge_detect).
module pulse_monitor
    import pulse_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 10,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8,
    parameter int CNT_W      = $clog2(EXP_PERIOD + TOLERANCE + 2) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_early,
    output logic             err_missing,
    output logic [ERR_W-1:0] err_count
);

    localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [31:0]      CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [31:0]      ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);
    localparam logic [CNT_W-1:0] LO      = CNT_W'(EXP_PERIOD - TOLERANCE);
    localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_PERIOD + TOLERANCE);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    logic pulse_ev;

    mon_state_e        state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [GOOD_W-1:0] good_q, good_n;
    logic [CNT_W-1:0]  period_n;
    logic              pv_n, early_n, miss_n;
    logic [ERR_W-1:0]  errc_n;
    logic              in_tol;

    pulse_edge_detect u_edge (
        .clk      (clk),
        .resetn   (resetn),
        .pulse_in (pulse_in),
        .pulse_ev (pulse_ev)
    );

    assign in_tol = (cnt_q >= LO) && (cnt_q <= HI);

    always_comb begin
        state_n  = state_q;
        cnt_n    = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
        good_n   = good_q;
        period_n = period;
        pv_n     = 1'b0;
        early_n  = 1'b0;
        miss_n   = 1'b0;
        errc_n   = err_count;

        if (clear) begin
            state_n  = MON_IDLE;
            cnt_n    = '0;
            good_n   = '0;
            period_n = '0;
            errc_n   = '0;
        end else begin
            if (pulse_ev) begin
                cnt_n    = CNT_W'(1);
                period_n = cnt_q;
            end

            unique case (state_q)
                MON_IDLE, MON_LOST: begin
                    // First event after IDLE/LOST only establishes the reference.
                    if (pulse_ev) begin
                        state_n = MON_SEARCH;
                        good_n  = '0;
                    end
                end
                MON_SEARCH: begin
                    if (pulse_ev) begin
                        pv_n = 1'b1;
                        if (in_tol) begin
                            if (good_q == GOOD_LAST) begin
                                state_n = MON_LOCKED;
                                good_n  = '0;
                            end else begin
                                good_n = good_q + GOOD_W'(1);
                            end
                        end else begin
                            good_n = '0;
                        end
                    end else if (cnt_q > HI) begin
                        good_n = '0;
                    end
                end
                MON_LOCKED: begin
                    if (pulse_ev) begin
                        pv_n = 1'b1;
                        if (cnt_q < LO) begin
                            early_n = 1'b1;
                            state_n = MON_SEARCH;
                            good_n  = '0;
                        end
                    end else if (cnt_q == HI) begin
                        miss_n  = 1'b1;
                        state_n = MON_LOST;
                    end
                end
                default: state_n = MON_IDLE;
            endcase

            if (early_n || miss_n) begin
                errc_n = ERR_W'(sat_inc(32'(err_count), ERR_MAX));
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= MON_IDLE;
            cnt_q        <= '0;
            good_q       <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            err_early    <= 1'b0;
            err_missing  <= 1'b0;
            err_count    <= '0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            good_q       <= good_n;
            period       <= period_n;
            period_valid <= pv_n;
            err_early    <= early_n;
            err_missing  <= miss_n;
            err_count    <= errc_n;
        end
    end

    assign locked = (state_q == MON_LOCKED);

endmodule

// File: tb/tb_pulse_monitor.sv
// Self-checking bench for pulse_monitor: default instance and a TOLERANCE=1 instance
// checked each cycle against a timestamp-based reference model.
module tb_pulse_monitor;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pulse_in = 1'b0;
    logic clear = 1'b0;

    logic [4:0] a_period, b_period;
    logic       a_pv, b_pv, a_locked, b_locked, a_early, b_early, a_miss, b_miss;
    logic [7:0] a_errc, b_errc;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    int p_exp [2] = '{10, 10};
    int p_tol [2] = '{0, 1};
    int p_lock[2] = '{3, 3};
    int cmax  [2];

    // Reference model: elapsed time derived from the last event timestamp.
    bit m_prev[2], m_hasref[2], m_lock[2], m_lost[2];
    bit m_pv[2], m_early[2], m_miss[2];
    int m_ref[2], m_good[2], m_period[2], m_errc[2];

    always #5 clk = ~clk;

    pulse_monitor dut_a (
        .clk(clk), .resetn(resetn), .pulse_in(pulse_in), .clear(clear),
        .period(a_period), .period_valid(a_pv), .locked(a_locked),
        .err_early(a_early), .err_missing(a_miss), .err_count(a_errc)
    );

    pulse_monitor #(.TOLERANCE(1)) dut_b (
        .clk(clk), .resetn(resetn), .pulse_in(pulse_in), .clear(clear),
        .period(b_period), .period_valid(b_pv), .locked(b_locked),
        .err_early(b_early), .err_missing(b_miss), .err_count(b_errc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset(input int k);
        m_prev[k] = 0; m_hasref[k] = 0; m_lock[k] = 0; m_lost[k] = 0;
        m_pv[k] = 0; m_early[k] = 0; m_miss[k] = 0;
        m_good[k] = 0; m_period[k] = 0; m_errc[k] = 0;
        m_ref[k] = edge_n + 1;
    endtask

    task automatic model_edge(input int k, input bit pin, input bit clr);
        bit ev;
        bit in_tol;
        int c;
        ev = pin && !m_prev[k];
        m_prev[k] = pin;
        c = edge_n - m_ref[k];
        if (c > cmax[k]) c = cmax[k];
        m_pv[k] = 0; m_early[k] = 0; m_miss[k] = 0;
        if (clr) begin
            m_hasref[k] = 0; m_lock[k] = 0; m_lost[k] = 0;
            m_good[k] = 0; m_period[k] = 0; m_errc[k] = 0;
            m_ref[k] = edge_n + 1;
            return;
        end
        in_tol = (c >= p_exp[k] - p_tol[k]) && (c <= p_exp[k] + p_tol[k]);
        if (ev) begin
            m_period[k] = c;
            m_ref[k] = edge_n;
        end
        if (!m_hasref[k]) begin
            if (ev) begin
                m_hasref[k] = 1; m_lost[k] = 0; m_good[k] = 0;
            end
        end else if (m_lock[k]) begin
            if (ev) begin
                m_pv[k] = 1;
                if (c < p_exp[k] - p_tol[k]) begin
                    m_early[k] = 1; m_lock[k] = 0; m_good[k] = 0;
                end
            end else if (c == p_exp[k] + p_tol[k]) begin
                m_miss[k] = 1; m_lock[k] = 0; m_lost[k] = 1; m_hasref[k] = 0;
            end
        end else begin
            if (ev) begin
                m_pv[k] = 1;
                if (in_tol) begin
                    m_good[k]++;
                    if (m_good[k] >= p_lock[k]) begin
                        m_lock[k] = 1; m_good[k] = 0;
                    end
                end else begin
                    m_good[k] = 0;
                end
            end else if (c > p_exp[k] + p_tol[k]) begin
                m_good[k] = 0;
            end
        end
        if ((m_early[k] || m_miss[k]) && m_errc[k] < 255) m_errc[k]++;
    endtask

    task automatic compare_all();
        check("a.period", 32'(a_period), m_period[0]);
        check("a.period_valid", 32'(a_pv), 32'(m_pv[0]));
        check("a.locked", 32'(a_locked), 32'(m_lock[0]));
        check("a.err_early", 32'(a_early), 32'(m_early[0]));
        check("a.err_missing", 32'(a_miss), 32'(m_miss[0]));
        check("a.err_count", 32'(a_errc), m_errc[0]);
        check("b.period", 32'(b_period), m_period[1]);
        check("b.period_valid", 32'(b_pv), 32'(m_pv[1]));
        check("b.locked", 32'(b_locked), 32'(m_lock[1]));
        check("b.err_early", 32'(b_early), 32'(m_early[1]));
        check("b.err_missing", 32'(b_miss), 32'(m_miss[1]));
        check("b.err_count", 32'(b_errc), m_errc[1]);
    endtask

    task automatic cyc(input bit p, input bit c);
        pulse_in = p;
        clear = c;
        @(posedge clk);
        edge_n++;
        model_edge(0, p, c);
        model_edge(1, p, c);
        #1;
        compare_all();
    endtask

    task automatic pulse_gap(input int n, input int w);
        for (int i = 0; i < n; i++) cyc(i < w, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmax[k] = (1 << ($clog2(p_exp[k] + p_tol[k] + 2) + 1)) - 1;
            model_reset(k);
        end
        #22;
        compare_all();
        resetn = 1'b1;
        model_reset(0);
        model_reset(1);

        // Nominal train of 5 pulses, then an early pulse after 7 cycles
        repeat (3) cyc(0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0);
            if (i == 1) check("t1.first_no_pv", 32'(a_pv), 0);
            else begin
                check("t1.period", 32'(a_period), 10);
                check("t1.pv", 32'(a_pv), 1);
            end
            if (i == 4) check("t1.locked_after_4", 32'(a_locked), 1);
            repeat ((i == 5) ? 6 : 9) cyc(0, 0);
        end
        check("t1.errc", 32'(a_errc), 0);
        cyc(1, 0);
        check("t2.early", 32'(a_early), 1);
        check("t2.period", 32'(a_period), 7);
        check("t2.unlocked", 32'(a_locked), 0);
        check("t2.errc", 32'(a_errc), 1);
        cyc(0, 0);
        check("t2.early_one_cycle", 32'(a_early), 0);

        // Relock, then pulses stop
        repeat (8) cyc(0, 0);
        for (int i = 0; i < 3; i++) pulse_gap(10, 1);
        cyc(1, 0);
        check("t3.relocked", 32'(a_locked), 1);
        for (int i = 1; i <= 12; i++) begin
            cyc(0, 0);
            if (i == 9)  check("t3.no_miss_yet", 32'(a_miss), 0);
            if (i == 10) begin
                check("t3.miss", 32'(a_miss), 1);
                check("t3.lost_unlocked", 32'(a_locked), 0);
            end
        end
        for (int i = 0; i < 4; i++) pulse_gap(10, 1);
        cyc(1, 0);
        check("t3.lock_after_resume", 32'(a_locked), 1);

        // Tolerance instance: periods 9, 11, 10, then 12
        cyc(0, 1);
        repeat (2) cyc(0, 0);
        pulse_gap(9, 1);
        pulse_gap(11, 1);
        pulse_gap(10, 1);
        cyc(1, 0);
        check("t4.b_locked", 32'(b_locked), 1);
        for (int i = 1; i <= 11; i++) begin
            cyc(0, 0);
            if (i == 11) check("t4.b_miss_at_11", 32'(b_miss), 1);
        end
        cyc(1, 0);

        // Held-high pulses, 3 cycles wide, period 10
        cyc(0, 1);
        for (int i = 0; i < 5; i++) pulse_gap(10, 3);
        check("t5.held_period", 32'(a_period), 10);
        check("t5.held_locked", 32'(a_locked), 1);

        // Clear coinciding with a pulse while locked
        cyc(1, 1);
        check("t6.clr_period", 32'(a_period), 0);
        check("t6.clr_locked", 32'(a_locked), 0);
        check("t6.clr_errc", 32'(a_errc), 0);
        repeat (4) cyc(0, 0);
        cyc(1, 0);
        check("t6.first_after_clear", 32'(a_pv), 0);

        // Random gaps, widths, occasional long gaps and clears
        for (int n = 0; n < 80; n++) begin
            int gap;
            int w;
            gap = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(5, 14));
            w = $urandom_range(1, 3);
            for (int i = 0; i < gap; i++) cyc(i < w, $urandom_range(0, 59) == 0);
        end

        // Asynchronous reset mid-count
        for (int i = 0; i < 5; i++) pulse_gap(10, 1);
        repeat (4) cyc(0, 0);
        resetn = 1'b0;
        #2;
        model_reset(0);
        model_reset(1);
        compare_all();
        check("t7.rst_period", 32'(a_period), 0);
        resetn = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        repeat (3) cyc(0, 0);
        for (int i = 0; i < 3; i++) pulse_gap(10, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
